// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared widths, defaults and pipeline records for mult_share_arb
package mult_arb_pkg;

    localparam int OPW      = 16;
    localparam int PRODW    = 32;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int IDMAXW   = 3;   // enough for up to 8 requesters

    typedef struct packed {
        logic                    v;
        logic [IDMAXW-1:0]       id;
        logic signed [OPW-1:0]   a;
        logic signed [OPW-1:0]   b;
    } s1_t;

    typedef struct packed {
        logic                    v;
        logic [IDMAXW-1:0]       id;
        logic signed [PRODW-1:0] prod;
    } s2_t;

endpackage

// File: rtl/mult_16_16_top.sv
// rtl/mult_16_16_top.sv - combinational 16x16 signed multiplier, exact 32-bit product
module mult_16_16_top
    import mult_arb_pkg::*;
(
    input  logic signed [OPW-1:0]   a_i,
    input  logic signed [OPW-1:0]   b_i,
    output logic signed [PRODW-1:0] prod_o
);

    assign prod_o = a_i * b_i;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant arbiter; round-robin when MULT_ARB_RR_EN is defined, else fixed priority
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    localparam int IW   = $clog2(NREQ)
) (
`ifdef MULT_ARB_RR_EN
    input  logic            clk_i,
    input  logic            rst_i,
`endif
    input  logic [NREQ-1:0] req_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

`ifdef MULT_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;
    int            c;

    // Search starts at ptr and wraps; the first requester found wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        c       = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NREQ) c = c - NREQ;
            cand = IW'(c);
            if (enable_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        ptr_d = ptr_q;
        if (found) ptr_d = (idx_o == IW'(NREQ-1)) ? '0 : idx_o + IW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    // Descending scan so the lowest requesting index is the last writer.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        if (enable_i) begin
            for (int k = NREQ-1; k >= 0; k--) begin
                if (req_i[IW'(k)]) begin
                    grant_o = NREQ'(1) << k;
                    idx_o   = IW'(k);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - NREQ-way valid/ready arbiter sharing one 16x16 signed multiplier (MULT_ARB_RR_EN selects round-robin)
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRODW-1:0]    rsp_prod
);

    localparam int IW = $clog2(NREQ);

    s1_t                     s1_q, s1_d;
    s2_t                     s2_q, s2_d;
    logic                    adv1, adv2;
    logic [NREQ-1:0]         grant;
    logic [IW-1:0]           gidx;
    logic signed [PRODW-1:0] prod;

    // A stage may take new data when it is empty or its downstream moves.
    assign adv2 = !s2_q.v || rsp_ready;
    assign adv1 = !s1_q.v || adv2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef MULT_ARB_RR_EN
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
`endif
        .req_i    (req_valid),
        .enable_i (adv1),
        .grant_o  (grant),
        .idx_o    (gidx)
    );

    mult_16_16_top u_mult (
        .a_i    (s1_q.a),
        .b_i    (s1_q.b),
        .prod_o (prod)
    );

    always_comb begin
        s1_d = s1_q;
        if (adv1) begin
            s1_d.v = |grant;
            if (|grant) begin
                s1_d.id = IDMAXW'(gidx);
                s1_d.a  = req_a[gidx*OPW +: OPW];
                s1_d.b  = req_b[gidx*OPW +: OPW];
            end
        end
        s2_d = s2_q;
        if (adv2) begin
            s2_d.v    = s1_q.v;
            s2_d.id   = s1_q.id;
            s2_d.prod = prod;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = s2_q.v;
    assign rsp_id    = IDW'(s2_q.id);
    assign rsp_prod  = s2_q.prod;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized scoreboard bench for mult_share_arb against a FIFO/arbitration reference model
module tb_mult_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                sys_clk = 1'b0;
    logic                sys_rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_a, req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_prod;

    logic [15:0]     ra [NREQ];
    logic [15:0]     rb [NREQ];
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] hs_last;

    int n_cmp = 0, n_fail = 0;
    int sb [NREQ][$];          // expected products per requester, issue order
    int inflight_t [$];        // handshake cycle of each product still in the pipe
    int cyc = 0, mcyc = 0, mptr = 0;
    int waitc [NREQ];
    int resp_cnt = 0;
    int log_prod [$], log_id [$], log_cyc [$];

    always #5 sys_clk = ~sys_clk;

    assign req_valid = rv;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*16 +: 16] = ra[i];
            req_b[i*16 +: 16] = rb[i];
        end
    end

    mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int mul(input logic [15:0] a, input logic [15:0] b);
        return int'($signed(a)) * int'($signed(b));
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7fff;
            2: return 16'hffff;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: two-deep FIFO with two-cycle latency plus the arbitration rule.
    always @(negedge sys_clk) begin : model_p
        int g, idx;
        bit ev;
        logic [NREQ-1:0] eg;
        if (sys_rst) begin
            inflight_t.delete();
            for (int i = 0; i < NREQ; i++) begin
                sb[i].delete();
                waitc[i] = 0;
            end
            mptr = 0;
        end else begin
            ev = inflight_t.size() > 0 && (cyc - inflight_t[0] >= 2);
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
            g = -1;
            if (!(inflight_t.size() == 2 && !rsp_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_RR_EN
                    idx = (mptr + k) % NREQ;
`else
                    idx = k;
`endif
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(eg));
            if (ev && rsp_ready) void'(inflight_t.pop_front());
            if (g >= 0) begin
                inflight_t.push_back(cyc);
                sb[g].push_back(mul(ra[g], rb[g]));
`ifdef MULT_ARB_RR_EN
                chk("rr_wait_bound", {31'b0, waitc[g] <= NREQ-1}, 32'd1);
                for (int i = 0; i < NREQ; i++)
                    if (i != g && req_valid[i]) waitc[i]++;
                waitc[g] = 0;
                mptr = (g + 1) % NREQ;
`endif
            end
        end
        cyc++;
    end

    // Monitor: every accepted response must match the oldest outstanding product of its requester.
    always @(negedge sys_clk) begin : mon_p
        int exp_p;
        if (!sys_rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", {31'b0, sb[rsp_id].size() > 0}, 32'd1);
            if (sb[rsp_id].size() > 0) begin
                exp_p = sb[rsp_id].pop_front();
                chk("rsp_prod", rsp_prod, exp_p);
            end
            log_prod.push_back(rsp_prod);
            log_id.push_back(int'(rsp_id));
            log_cyc.push_back(mcyc);
            resp_cnt++;
        end
        mcyc++;
    end

    task automatic step();
        @(negedge sys_clk);
        hs_last = req_valid & req_ready;
        @(posedge sys_clk);
        #1;
        rv = rv & ~hs_last;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int t;
        t = 0;
        while (resp_cnt < n && t < budget) begin
            step();
            t++;
        end
        chk("resp_timeout", {31'b0, resp_cnt >= n}, 32'd1);
    endtask

    task automatic clear_log();
        log_prod.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    function automatic int sb_total();
        int s;
        s = 0;
        for (int i = 0; i < NREQ; i++) s += sb[i].size();
        return s;
    endfunction

    initial begin : main_p
        int prev, g, nacc, issued, t, base;
        logic [31:0] hold_p;
        logic [IDW-1:0] hold_id;
        sys_rst = 1'b1;
        rv = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        repeat (3) step();
        sys_rst = 1'b0;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_prod", rsp_prod, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Most-negative squared must not overflow
        clear_log();
        base = resp_cnt;
        ra[2] = 16'h8000; rb[2] = 16'h8000; rv[2] = 1'b1;
        wait_resp(base + 1, 20);
        if (log_prod.size() >= 1) begin
            chk("min_sq_prod", log_prod[0], 32'h4000_0000);
            chk("min_sq_id", log_id[0], 32'd2);
        end

        // Two requesters back to back give consecutive responses
        clear_log();
        base = resp_cnt;
        ra[0] = 16'h7fff; rb[0] = 16'h8000; rv[0] = 1'b1;
        ra[1] = 16'hffff; rb[1] = 16'hffff; rv[1] = 1'b1;
        wait_resp(base + 2, 20);
        if (log_prod.size() >= 2) begin
            chk("b2b_prod0", log_prod[0], 32'hC000_8000);
            chk("b2b_id0", log_id[0], 32'd0);
            chk("b2b_prod1", log_prod[1], 32'h0000_0001);
            chk("b2b_id1", log_id[1], 32'd1);
            chk("b2b_consecutive", log_cyc[1] - log_cyc[0], 32'd1);
        end

        // All requesters hold valid: grant order
        prev = -1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16'(i + 3); rb[i] = 16'(-(i + 1));
        end
        rv = '1;
        for (int s = 0; s < 12; s++) begin
            step();
            g = onehot_idx(hs_last);
`ifdef MULT_ARB_RR_EN
            if (prev >= 0) chk("rr_order", g, (prev + 1) % NREQ);
`else
            chk("fixed_order", g, 32'd0);
`endif
            prev = g;
            rv = '1;
        end
        rv = '0;
        repeat (4) step();

        // Backpressure from an empty pipe: exactly two accepted, output held
        rsp_ready = 1'b0;
        rv = '1;
        nacc = 0;
        hold_p = '0;
        hold_id = '0;
        for (int s = 1; s <= 5; s++) begin
            step();
            nacc += $countones(hs_last);
            rv = '1;
            if (s == 2) begin
                hold_p = rsp_prod;
                hold_id = rsp_id;
            end
            if (s > 2) begin
                chk("stall_prod_stable", rsp_prod, hold_p);
                chk("stall_id_stable", 32'(rsp_id), 32'(hold_id));
                chk("stall_req_ready", 32'(req_ready), 32'd0);
            end
        end
        chk("stall_accepted", nacc, 32'd2);
        rsp_ready = 1'b1;
        rv = '0;
        repeat (5) step();
        chk("stall_drained", sb_total(), 32'd0);

        // Reset with both stages full discards everything in flight
        rv = '1;
        repeat (3) step();
        sys_rst = 1'b1;
        rv = '0;
        step();
        sys_rst = 1'b0;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_rsp_prod", rsp_prod, 32'd0);
        chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
        repeat (4) step();
        rv = '1;
        step();
        chk("midrst_ptr_zero", onehot_idx(hs_last), 32'd0);
        rv = '0;
        repeat (4) step();

        // Random sweep
        issued = 0;
        t = 0;
        while (issued < 10000 && t < 40000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && $urandom_range(0, 2) != 0) begin
                    ra[i] = rand_op();
                    rb[i] = rand_op();
                    rv[i] = 1'b1;
                    issued++;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            t++;
        end
        chk("rand_issued", {31'b0, issued >= 10000}, 32'd1);
        rsp_ready = 1'b1;
        t = 0;
        while (rv != '0 && t < 100) begin
            step();
            t++;
        end
        chk("rand_all_accepted", 32'(rv), 32'd0);
        repeat (4) step();
        chk("rand_drained", sb_total(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Shares one combinational 16x16 signed multiplier (mult_16_16_top) among NREQ requesters. Each request is accepted through a valid/ready handshake, its operands are registered into the multiplier, and the registered 32-bit product is returned tagged with the requester index. The arbiter sits between the DSP clients and the single multiplier instance, so the Booth-4/Wallace array is time-shared rather than replicated.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of rsp_id; must be at least clog2(NREQ)
- sys_clk  in  1  single clock, rising edge
- sys_rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle; one-hot or zero
- req_a  in  16*NREQ  signed multiplicand, slice i belongs to requester i
- req_b  in  16*NREQ  signed multiplier, slice i belongs to requester i
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  IDW  index of the requester that owns rsp_prod
- rsp_prod  out  32  signed product, two's complement, exact (no truncation)

## Operation
- Two register stages. S1 holds {a, b, id, v1}; the multiplier is driven combinationally from S1. S2 holds {prod, id, v2}, which drives the rsp_* outputs.
- adv2 = !v2 | rsp_ready. adv1 = !v1 | adv2.
- Grant: when adv1 = 1, the arbiter picks one requester with req_valid set and raises its req_ready. When adv1 = 0, req_ready is all zeros.
- req_ready may depend combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- A handshake on requester i (req_valid[i] & req_ready[i]) loads S1 with that requester's slices and id = i, and sets v1.
- When adv1 = 1 and there is no handshake, v1 clears.
- When adv2 = 1, S2 loads {product(S1), S1.id} and v2 = v1.
- Round-robin order (see Configuration): search starts at ptr and wraps modulo NREQ. After each handshake, ptr becomes grantee+1, wrapping to 0 after NREQ-1. Without a handshake, ptr is unchanged.
- Arithmetic: the product is the full 32-bit signed result. -32768 * -32768 = 0x40000000 with no overflow.
- Reset values: v1 = v2 = 0, ptr = 0, S1 and S2 data = 0, so rsp_prod = 0 and rsp_id = 0. req_ready and rsp_valid are 0 in the cycle after reset.
- Reset in mid-operation discards in-flight requests and produces no response for them.

## Timing
- Latency: a handshake at edge k makes rsp_valid = 1 after edge k+1, i.e. two cycles from request to response.
- Throughput: one product per cycle when rsp_ready is held high.
- Backpressure: with rsp_valid = 1 and rsp_ready = 0, S2 holds its value stable. S1 can still fill once if it is empty; after that req_ready = 0 until the stall clears.
- A simultaneous S2 drain and new S1 load in the same cycle is legal. No bubble is inserted.
- The whole S1 stage is in a single cycle: the multiplier's critical path is S1 register to S2 register.

## Configuration
- MULT_ARB_RR_EN defined: round-robin arbitration using ptr as described above. This guarantees a grant within NREQ handshakes for any requester that holds valid.
- Not defined: fixed priority, lowest index wins. ptr logic is removed and higher indices can starve.

## Structure
- Package mult_arb_pkg holds:
  - operand width 16 and product width 32
  - default NREQ and IDW
  - the S1 and S2 record typedefs
- Sub-module rr_arbiter (NREQ): inputs req and enable; outputs a one-hot grant and an encoded index. It holds ptr internally and contains both the MULT_ARB_RR_EN and fixed-priority variants.
- mult_16_16_top is instantiated once between S1 and S2.

## Test plan
- Single request from requester 2, a = -32768, b = -32768, rsp_ready = 1 → rsp_valid two cycles later with rsp_prod = 0x40000000, rsp_id = 2.
- Requester 0, a = 32767, b = -32768 → rsp_prod = 0xC0008000. Requester 1, a = -1, b = -1 → rsp_prod = 0x00000001. Issued back-to-back, the responses appear on consecutive cycles.
- All four requesters hold valid continuously with RR_EN defined → grant order 0,1,2,3,0,… Without RR_EN, requester 0 is granted every cycle.
- rsp_ready held 0 for 5 cycles with continuous requests → exactly two requests accepted, rsp_prod and rsp_id stable, req_ready = 0. On release, the outputs drain in order and nothing is lost or duplicated.
- sys_rst asserted for one cycle while S1 and S2 are both valid → next cycle rsp_valid = 0, rsp_prod = 0, ptr = 0, and no stale response ever appears.
- Random sweep: 10k random a and b values with random valids and random rsp_ready → every rsp_prod equals a*b as a signed 32-bit value, ids match the issue order per requester, and no requester waits more than NREQ grants (RR_EN).
